// File: rtl/issue_scoreboard.sv
// issue_scoreboard: register-dependency scoreboard and issue controller.
// Keeps a pending-write bitmap of destination registers between issue and
// writeback, and stalls decode on RAW/WAW hazards or a full write window.
// Optional feature: define SCB_WB_BYPASS_EN so that a writeback in the current
// cycle hides its register from the hazard checks and a waiting consumer issues
// in that same cycle.
module issue_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int MAX_OUT  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [REG_AW-1:0]   issue_rs1,
  input  logic [REG_AW-1:0]   issue_rs2,
  input  logic [REG_AW-1:0]   issue_rd,
  input  logic                issue_use_rs1,
  input  logic                issue_use_rs2,
  input  logic                issue_wr_rd,
  input  logic                wb_valid,
  input  logic [REG_AW-1:0]   wb_rd,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [3:0]          outstanding,
  output logic                stall,
  output logic                spurious_wb
);

  logic [NUM_REGS-1:0] r_busy;
  logic [3:0]          r_outstanding;
  logic                r_spurious_wb;

  logic [NUM_REGS-1:0] w_set_vec;
  logic [NUM_REGS-1:0] w_clr_vec;
  logic [NUM_REGS-1:0] w_bypass_vec;
  logic [NUM_REGS-1:0] w_busy_chk;
  logic                w_wb_hit;
  logic                w_wb_spurious;
  logic                w_tracked;
  logic                w_full;
  logic                w_raw1;
  logic                w_raw2;
  logic                w_waw;
  logic                w_set;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [3:0]          w_out_nxt;
  logic                w_spurious_nxt;

  // One-hot decodes of the destination being issued and the register written back.
  assign w_set_vec = NUM_REGS'(1) << issue_rd;
  assign w_clr_vec = NUM_REGS'(1) << wb_rd;

  // x0 is never tracked, so a writeback to it is neither a hit nor an error.
  assign w_wb_hit      = wb_valid && (wb_rd != '0) &&  r_busy[wb_rd];
  assign w_wb_spurious = wb_valid && (wb_rd != '0) && !r_busy[wb_rd];

`ifdef SCB_WB_BYPASS_EN
  // The register being retired this cycle no longer blocks its consumers.
  assign w_bypass_vec = w_wb_hit ? w_clr_vec : '0;
`else
  assign w_bypass_vec = '0;
`endif

  assign w_busy_chk = r_busy & ~w_bypass_vec;

  assign w_raw1    = issue_use_rs1 && (issue_rs1 != '0) && w_busy_chk[issue_rs1];
  assign w_raw2    = issue_use_rs2 && (issue_rs2 != '0) && w_busy_chk[issue_rs2];
  assign w_waw     = issue_wr_rd   && (issue_rd  != '0) && w_busy_chk[issue_rd];
  assign w_tracked = issue_wr_rd   && (issue_rd  != '0);
  // The window check uses the registered count: a same-cycle writeback does
  // not free a slot until the next cycle.
  assign w_full    = (r_outstanding == 4'(MAX_OUT));

  assign issue_ready = !flush && !w_raw1 && !w_raw2 && !w_waw && !(w_tracked && w_full);
  assign stall       = issue_valid && !issue_ready;
  assign w_set       = issue_valid && issue_ready && w_tracked;

  // Next-state: flush wipes tracking; otherwise clear on writeback, then set on issue
  // so that a same-register set/clear pair leaves the bit set.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
    w_busy_nxt     = r_busy;
    w_out_nxt      = r_outstanding;
    w_spurious_nxt = r_spurious_wb;
    if (flush) begin
      w_busy_nxt = '0;
      w_out_nxt  = '0;
    end else begin
      if (w_wb_hit) w_busy_nxt = w_busy_nxt & ~w_clr_vec;
      if (w_set)    w_busy_nxt = w_busy_nxt |  w_set_vec;
      if (w_set && !w_wb_hit)      w_out_nxt = r_outstanding + 4'd1;
      else if (!w_set && w_wb_hit) w_out_nxt = r_outstanding - 4'd1;
      if (w_wb_spurious) w_spurious_nxt = 1'b1;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!reset) begin
      r_busy        <= '0;
      r_outstanding <= '0;
      r_spurious_wb <= 1'b0;
    end else begin
      r_busy        <= w_busy_nxt;
      r_outstanding <= w_out_nxt;
      r_spurious_wb <= w_spurious_nxt;
    end
  end

  assign busy_vec    = r_busy;
  assign outstanding = r_outstanding;
  assign spurious_wb = r_spurious_wb;

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Register-dependency scoreboard and issue controller for the RISC-V core. Tracks which destination registers have results still in flight between issue and register-file writeback. Stalls the decode stage on RAW and WAW hazards and on a full outstanding-write window. Sits between `Instruction_decode` and the execute/writeback path and gates issue into `Execution_Unit_ALU` and the register-file write port.

## Interface
- `NUM_REGS`, 32: architectural registers; x0 is never tracked.
- `REG_AW`, 5: register index width; equals clog2(`NUM_REGS`).
- `MAX_OUT`, 4: maximum in-flight register writes; range 1..15.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; asserting 0 clears all state immediately.
- `issue_valid` in 1: decode presents an instruction.
- `issue_ready` out 1: scoreboard accepts it; the transfer happens when `issue_valid && issue_ready`.
- `issue_rs1`, `issue_rs2`, `issue_rd` in `REG_AW`: register indices.
- `issue_use_rs1`, `issue_use_rs2`, `issue_wr_rd` in 1: operand-use and destination-write qualifiers.
- `wb_valid` in 1: writeback of `wb_rd` this cycle.
- `wb_rd` in `REG_AW`: register being written back.
- `flush` in 1: discard all in-flight tracking (branch redirect).
- `busy_vec` out `NUM_REGS`: registered pending-write bitmap; bit 0 is always 0.
- `outstanding` out 4: registered count of pending writes.
- `stall` out 1: equals `issue_valid && !issue_ready`.
- `spurious_wb` out 1: sticky error flag; set by a writeback to a non-busy register.

## Operation
- hazard_raw1 = `issue_use_rs1` && rs1≠0 && busy[rs1]. hazard_raw2 is the same for rs2. hazard_waw = `issue_wr_rd` && rd≠0 && busy[rd].
- A tracked issue is an accepted issue with `issue_wr_rd` && rd≠0.
- `issue_ready` = !`flush` && !hazard_raw1 && !hazard_raw2 && !hazard_waw && !(tracked issue pending && `outstanding`==`MAX_OUT`).
- An accepted issue whose `issue_wr_rd` is 0, or whose rd is 0, does not affect state. The full-window check does not apply to it.
- On a tracked issue: busy[rd] is set and `outstanding` increments.
- A valid writeback is `wb_valid` with busy[wb_rd]=1 and wb_rd≠0. It clears busy[wb_rd] and decrements `outstanding`.
- `wb_valid` with wb_rd=0: no effect, no error.
- `wb_valid` with a non-busy wb_rd≠0: no state change, and `spurious_wb` is set.
- A tracked issue and a valid writeback in the same cycle leave `outstanding` unchanged. If both name the same register, the set wins; this is only reachable with bypass enabled.
- `flush`: next cycle all busy bits are 0 and `outstanding` is 0. An issue or writeback in the flush cycle is ignored, and no `spurious_wb` is raised.
- `outstanding` never exceeds `MAX_OUT` and never underflows.
- Invariant: `outstanding` equals the popcount of `busy_vec`.

## Timing
- Reset values: `busy_vec`=0, `outstanding`=0, `spurious_wb`=0. `issue_ready` is 1 out of reset unless `flush` is high.
- `issue_ready` and `stall` are combinational from the registered state and the current inputs. There is no registered delay on the handshake.
- State updates take effect at the rising edge after the accepting cycle. A dependent instruction presented the cycle after its producer issues sees the busy bit and stalls.
- Without bypass, the earliest cycle a stalled consumer can issue is the cycle after the writeback.
- `spurious_wb` holds from the cycle after the event until reset. `flush` does not clear it.
- Reset asserted mid-stall: all outputs take their reset values asynchronously. The instruction presented on `issue_valid` is accepted once `reset` deasserts, if there is no flush.

## Configuration
- `SCB_WB_BYPASS_EN` defined: a valid writeback in the current cycle masks its register from the hazard checks. A consumer waiting on that register issues in the same cycle as the writeback. A same-register WAW issue sets busy, because the set wins over the clear.
- `SCB_WB_BYPASS_EN` undefined: hazard checks use the registered `busy_vec` only, giving one extra stall cycle relative to the writeback.

## Test plan
- Reset → `busy_vec`=0, `outstanding`=0, `spurious_wb`=0, `issue_ready`=1. Then issue rd=5 → next cycle busy[5]=1 and `outstanding`=1.
- RAW stall: issue rd=5, then present rs1=5 with `issue_use_rs1`=1 → `stall`=1 until writeback of rd=5. Without bypass, issue happens the cycle after the writeback; with bypass, in the same cycle.
- Window full: with `MAX_OUT`=4, issue rd=1,2,3,4 → `outstanding`=4, and a tracked issue to rd=6 stalls. Issue with rd=0 is still accepted. Writeback rd=2 → rd=6 issues next cycle.
- Simultaneous tracked issue rd=7 and writeback rd=1 → `outstanding` unchanged, busy[7]=1, busy[1]=0.
- Flush with busy[3], busy[9] set, plus an issue valid in the same cycle → `issue_ready`=0 during the flush cycle. Next cycle `busy_vec`=0 and `outstanding`=0.
- Writeback rd=12 while busy[12]=0 → `spurious_wb`=1 and stays 1 after a flush. Reset pulsed mid-cycle → everything clears immediately.
